// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response channels for IF and D plus the shared RAM port.
interface mem_port_arbiter_if #(parameter int XLEN = 32);
  logic            if_req_valid;
  logic            if_req_ready;
  logic [XLEN-1:0] if_addr;
  logic            if_resp_valid;
  logic [XLEN-1:0] if_resp_data;
  logic            d_req_valid;
  logic            d_req_ready;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_resp_valid;
  logic [XLEN-1:0] d_resp_data;
  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
    output if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req_valid, if_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
    input  if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency RAM port between fetch and data, D-priority with IF starvation guard.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {OWN_IF, OWN_D} owner_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic       if_gnt, d_gnt;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       resp_pend_q, resp_pend_d;
  owner_e     resp_owner_q, resp_owner_d;
  logic       resp_wr_q, resp_wr_d;
  always_comb begin
    d_gnt        = !rst && bus.d_req_valid && !(bus.if_req_valid && starve_cnt_q == LIMIT);
    if_gnt       = !rst && bus.if_req_valid && !d_gnt;
    starve_cnt_d = (!bus.if_req_valid || if_gnt) ? 4'd0 :
                   (d_gnt && starve_cnt_q != LIMIT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
    resp_pend_d  = if_gnt || d_gnt;
    resp_owner_d = d_gnt ? OWN_D : OWN_IF;
    resp_wr_d    = d_gnt && bus.d_we;
  end
  assign bus.if_req_ready  = if_gnt;
  assign bus.d_req_ready   = d_gnt;
  assign bus.mem_en        = if_gnt || d_gnt;
  assign bus.mem_we        = d_gnt && bus.d_we;
  assign bus.mem_addr      = if_gnt ? bus.if_addr : d_gnt ? bus.d_addr : {XLEN{1'b0}};
  assign bus.mem_wdata     = d_gnt ? bus.d_wdata : {XLEN{1'b0}};
  // Responses come straight from the RAM output; stores acknowledge with zero data.
  assign bus.if_resp_valid = resp_pend_q && resp_owner_q == OWN_IF;
  assign bus.if_resp_data  = bus.if_resp_valid ? bus.mem_rdata : {XLEN{1'b0}};
  assign bus.d_resp_valid  = resp_pend_q && resp_owner_q == OWN_D;
  assign bus.d_resp_data   = (bus.d_resp_valid && !resp_wr_q) ? bus.mem_rdata : {XLEN{1'b0}};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      resp_pend_q  <= 1'b0;
      resp_owner_q <= OWN_IF;
      resp_wr_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      resp_pend_q  <= resp_pend_d;
      resp_owner_q <= resp_owner_d;
      resp_wr_q    <= resp_wr_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors against a 1-cycle synchronous RAM model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] ram [256];
  logic [31:0] rdata_q = 32'd0;
  logic if_wait_q = 1'b0;
  logic d_wait_q = 1'b0;
  mem_port_arbiter_if #(.XLEN(32)) bus ();
  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = rdata_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[9:2]] = bus.mem_wdata;
      else rdata_q <= ram[bus.mem_addr[9:2]];
    end
  end
  // Requesters must hold valid until granted.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(if_wait_q && !bus.if_req_valid)) else $error("protocol: if valid dropped before grant");
      assert (!(d_wait_q && !bus.d_req_valid)) else $error("protocol: d valid dropped before grant");
    end
    if_wait_q <= !rst && bus.if_req_valid && !bus.if_req_ready;
    d_wait_q  <= !rst && bus.d_req_valid && !bus.d_req_ready;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic iv, input logic [31:0] ia, input logic dv, input logic dw,
                     input logic [31:0] da, input logic [31:0] dd);
    bus.if_req_valid = iv;
    bus.if_addr      = ia;
    bus.d_req_valid  = dv;
    bus.d_we         = dw;
    bus.d_addr       = da;
    bus.d_wdata      = dd;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    ram['h100 >> 2] = 32'hDEADBEEF;
    ram[0]          = 32'hA0A00000;
    ram[1]          = 32'hC0C00004;
    ram['h80 >> 2]  = 32'hB0B00080;
    req(1, 'h100, 1, 1, 'h200, 'h55);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_if_rdy", 32'(bus.if_req_ready), 0);
    chk("rst_d_rdy", 32'(bus.d_req_ready), 0);
    chk("rst_if_rv", 32'(bus.if_resp_valid), 0);
    chk("rst_d_rv", 32'(bus.d_resp_valid), 0);
    chk("rst_if_rd", bus.if_resp_data, 0);
    chk("rst_d_rd", bus.d_resp_data, 0);
    chk("rst_en", 32'(bus.mem_en), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_starve", 32'(dut.starve_cnt_q), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_d_rdy", 32'(bus.d_req_ready), 1);
    chk("rel_if_rdy", 32'(bus.if_req_ready), 0);
    chk("rel_we", 32'(bus.mem_we), 1);
    chk("rel_wdata", bus.mem_wdata, 'h55);
    chk("rel_addr", bus.mem_addr, 'h200);
    tick();
    req(1, 'h100, 0, 0, 0, 0);
    #1;
    chk("if_rdy", 32'(bus.if_req_ready), 1);
    chk("if_en", 32'(bus.mem_en), 1);
    chk("if_we", 32'(bus.mem_we), 0);
    chk("if_addr", bus.mem_addr, 'h100);
    chk("st0_d_rv", 32'(bus.d_resp_valid), 1);
    chk("st0_d_rd", bus.d_resp_data, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    #1;
    chk("if_rv", 32'(bus.if_resp_valid), 1);
    chk("if_rd", bus.if_resp_data, 32'hDEADBEEF);
    chk("if_d_rv", 32'(bus.d_resp_valid), 0);
    chk("idle_en", 32'(bus.mem_en), 0);
    chk("idle_addr", bus.mem_addr, 0);
    tick();
    req(0, 0, 1, 1, 'h40, 32'h12345678);
    #1;
    chk("st_rdy", 32'(bus.d_req_ready), 1);
    chk("st_we", 32'(bus.mem_we), 1);
    chk("st_wdata", bus.mem_wdata, 32'h12345678);
    tick();
    req(0, 0, 1, 0, 'h40, 0);
    #1;
    chk("ld_rdy", 32'(bus.d_req_ready), 1);
    chk("ld_we", 32'(bus.mem_we), 0);
    chk("st_rv", 32'(bus.d_resp_valid), 1);
    chk("st_rd", bus.d_resp_data, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    #1;
    chk("ld_rv", 32'(bus.d_resp_valid), 1);
    chk("ld_rd", bus.d_resp_data, 32'h12345678);
    chk("ld_if_rv", 32'(bus.if_resp_valid), 0);
    tick();
    req(1, 0, 1, 0, 'h80, 0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("sv_cnt%0d", k), 32'(dut.starve_cnt_q), 32'(k % 5));
      chk($sformatf("sv_if%0d", k), 32'(bus.if_req_ready), 32'(k % 5 == 4));
      chk($sformatf("sv_d%0d", k), 32'(bus.d_req_ready), 32'(k % 5 != 4));
      chk($sformatf("sv_ifrv%0d", k), 32'(bus.if_resp_valid), 32'(k == 5));
      chk($sformatf("sv_drv%0d", k), 32'(bus.d_resp_valid), 32'(k >= 1 && k != 5));
      tick();
    end
    req(0, 0, 1, 0, 'h80, 0);
    #1;
    chk("sv_end_d", 32'(bus.d_req_ready), 1);
    chk("sv_end_ifrv", 32'(bus.if_resp_valid), 1);
    chk("sv_end_cnt", 32'(dut.starve_cnt_q), 0);
    tick();
    req(1, 'h0, 0, 0, 0, 0);
    #1;
    chk("il0_rdy", 32'(bus.if_req_ready), 1);
    chk("il0_drd", bus.d_resp_data, 32'hB0B00080);
    tick();
    req(0, 0, 1, 0, 'h80, 0);
    #1;
    chk("il1_rdy", 32'(bus.d_req_ready), 1);
    chk("il1_ifrv", 32'(bus.if_resp_valid), 1);
    chk("il1_ifrd", bus.if_resp_data, 32'hA0A00000);
    chk("il1_drv", 32'(bus.d_resp_valid), 0);
    tick();
    req(1, 'h4, 0, 0, 0, 0);
    #1;
    chk("il2_rdy", 32'(bus.if_req_ready), 1);
    chk("il2_drv", 32'(bus.d_resp_valid), 1);
    chk("il2_drd", bus.d_resp_data, 32'hB0B00080);
    chk("il2_ifrv", 32'(bus.if_resp_valid), 0);
    chk("il2_ifrd", bus.if_resp_data, 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    #1;
    chk("il3_ifrv", 32'(bus.if_resp_valid), 1);
    chk("il3_ifrd", bus.if_resp_data, 32'hC0C00004);
    chk("il3_drv", 32'(bus.d_resp_valid), 0);
    tick();
    req(1, 'h100, 0, 0, 0, 0);
    #1;
    chk("mr_rdy", 32'(bus.if_req_ready), 1);
    tick();
    req(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mr_ifrv", 32'(bus.if_resp_valid), 0);
    chk("mr_ifrd", bus.if_resp_data, 0);
    chk("mr_en", 32'(bus.mem_en), 0);
    tick();
    rst = 1'b0;
    req(1, 'h100, 0, 0, 0, 0);
    #1;
    chk("mr2_rdy", 32'(bus.if_req_ready), 1);
    chk("mr2_ifrv", 32'(bus.if_resp_valid), 0);
    tick();
    req(0, 0, 0, 0, 0, 0);
    #1;
    chk("mr3_ifrv", 32'(bus.if_resp_valid), 1);
    chk("mr3_ifrd", bus.if_resp_data, 32'hDEADBEEF);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between two requesters: instruction fetch (IF) and load/store data (D).
- Memory is a synchronous RAM with a 1-cycle read latency. It accepts one access per cycle, fully pipelined.
- D has priority by default. A starvation counter forces an IF grant after too many consecutive D grants while IF waits.
- Responses are routed back to the requester that issued the access.

Parameters:
- XLEN, 32, data and address width.
- STARVE_LIMIT, 4, maximum consecutive D grants while IF is waiting (range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch granted this cycle.
- if_addr  in  XLEN  fetch address.
- if_resp_valid  out  1  fetch data valid.
- if_resp_data  out  XLEN  fetched instruction word.
- d_req_valid  in  1  data request.
- d_req_ready  out  1  data granted this cycle.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_resp_valid  out  1  load data or store acknowledge.
- d_resp_data  out  XLEN  load data (0 for stores).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Handshake and grant:
  - A transfer occurs on a cycle where req_valid && req_ready.
  - A requester holds valid, address and data stable until it is granted.
  - Ready is combinational from the valid inputs and the starvation state.
  - At most one grant per cycle. A grant is possible every cycle; there are no bubbles.
- Grant rules:
  - Only one valid → that requester is granted.
  - Both valid and starve_cnt < STARVE_LIMIT → D granted.
  - Both valid and starve_cnt == STARVE_LIMIT → IF granted.
  - Neither valid → no grant, mem_en=0.
- Memory side (combinational from the granted requester):
  - mem_en=1 on a grant.
  - For an IF grant, mem_addr=if_addr and mem_we=0.
  - For a D grant, mem_addr=d_addr, mem_we=d_we and mem_wdata=d_wdata.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Starvation counter (starve_cnt, 4 bits):
  - Increments on a cycle where D is granted while if_req_valid=1; saturates at STARVE_LIMIT.
  - Clears on any IF grant, or on any cycle where if_req_valid=0.
- Response pipeline:
  - On each grant, register resp_pend=1, resp_owner (IF/D) and resp_is_write.
  - The cycle after an IF grant: if_resp_valid=1 and if_resp_data=mem_rdata.
  - The cycle after a D load grant: d_resp_valid=1 and d_resp_data=mem_rdata.
  - The cycle after a D store grant: d_resp_valid=1 and d_resp_data=0.
  - The non-owner's resp_valid is 0 and its resp_data is 0.
  - Responses cannot be back-pressured; requesters must accept them.
  - Back-to-back grants produce back-to-back responses in grant order, latency exactly 1.
- Reset (async assert, sync deassert by upstream):
  - resp_pend=0 and starve_cnt=0.
  - Every output is 0: readies, resp_valids, resp_data, mem_*.
  - While rst is high, no grant is issued.
  - An access issued the cycle before reset produces no response. Requesters re-issue after reset.
- Boundaries:
  - Simultaneous new grant and returning response is the normal pipelined case; both are handled in the same cycle.
  - A requester dropping valid without a grant is a protocol violation. It is flagged by a bench assertion; the RTL behaviour is unspecified.

Test Plan:
- Reset: rst=1 with both valids high → all outputs 0. Release; next cycle → d_req_ready=1, if_req_ready=0.
- IF only:
  - Stimulus: if_addr=0x100 with memory word 0xDEADBEEF.
  - Cycle N: if_req_ready=1, mem_en=1, mem_we=0, mem_addr=0x100.
  - Cycle N+1: if_resp_valid=1, if_resp_data=0xDEADBEEF, d_resp_valid=0.
- Store then load:
  - D store of 0x12345678 to 0x40, then a D load from 0x40 on the next cycle.
  - Responses: d_resp_valid on both following cycles, data 0 then 0x12345678.
- Starvation:
  - Both valid continuously, STARVE_LIMIT=4.
  - Grant sequence: D, D, D, D, IF, D, D, D, D, IF.
  - starve_cnt runs 0..4 and clears on each IF grant.
- Interleaved pipelining: alternating grants IF@0x0, D load@0x80, IF@0x4 → responses on consecutive cycles, each routed to the correct port with correct data.
- Reset mid-operation: assert rst the cycle after an IF grant → if_resp_valid stays 0. After release, re-issued fetch completes normally.
